// File: rtl/boot_loader.sv
// UART boot loader: receives a word count followed by big-endian 32-bit words
// over a UART line, writes them into instruction memory, and holds the CPU in
// reset until the load is complete.
module boot_loader #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DEPTH_WORDS  = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rx,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        frame_err
);

   localparam int             CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [31:0]    DEPTH_U   = 32'(DEPTH_WORDS);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [1:0] {L_COUNT, L_LOAD, L_DONE} ld_state_t;

   rx_state_t       rx_state, rx_next;
   ld_state_t       ld_state, ld_next;

   logic            rx_meta, rx_sync, rx_prev;
   logic [CW-1:0]   clk_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shift_reg;
   logic            mid_hit, bit_hit, fall_edge;
   logic            byte_ok, byte_bad;

   logic [7:0]      word_total;
   logic [7:0]      word_cnt;
   logic [1:0]      byte_cnt;
   logic [23:0]     word_buf;
   logic            finish_pending;

   assign mid_hit   = (clk_cnt == HALF_LAST);
   assign bit_hit   = (clk_cnt == BIT_LAST);
   assign fall_edge = rx_prev & ~rx_sync;

   // Two-flop synchronizer plus a delayed copy for falling-edge detection
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // Receiver state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) rx_state <= R_IDLE;
      else        rx_state <= rx_next;
   end

   // Receiver next-state: start-bit midpoint check, 8 data bits, stop bit
   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         R_IDLE:  if (fall_edge) rx_next = R_START;
         R_START: if (mid_hit)   rx_next = rx_sync ? R_IDLE : R_DATA;
         R_DATA:  if (bit_hit && bit_cnt == 3'd7) rx_next = R_STOP;
         R_STOP:  if (bit_hit)   rx_next = R_IDLE;
         default: rx_next = R_IDLE;
      endcase
   end

   // Receiver outputs: a byte is reported on the stop-bit sample edge
   always_comb begin
      byte_ok  = 1'b0;
      byte_bad = 1'b0;
      if (rx_state == R_STOP && bit_hit) begin
         byte_ok  = rx_sync;
         byte_bad = ~rx_sync;
      end
   end

   // Receiver bit timing counters and LSB-first shift register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         clk_cnt   <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         case (rx_state)
            R_IDLE: begin
               clk_cnt <= '0;
               bit_cnt <= '0;
            end
            R_START: clk_cnt <= mid_hit ? '0 : clk_cnt + CW'(1);
            R_DATA: begin
               if (bit_hit) begin
                  clk_cnt   <= '0;
                  shift_reg <= {rx_sync, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 3'd1;
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            R_STOP:  clk_cnt <= bit_hit ? '0 : clk_cnt + CW'(1);
            default: clk_cnt <= '0;
         endcase
      end
   end

   // Loader state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) ld_state <= L_COUNT;
      else        ld_state <= ld_next;
   end

   // Loader next-state: count byte, then words, then terminal done
   always_comb begin
      ld_next = ld_state;
      case (ld_state)
         L_COUNT: if (byte_ok) ld_next = (shift_reg == 8'd0) ? L_DONE : L_LOAD;
         L_LOAD:  if (finish_pending) ld_next = L_DONE;
         L_DONE:  ld_next = L_DONE;
         default: ld_next = L_COUNT;
      endcase
   end

   // Loader outputs decoded from the state
   always_comb begin
      done     = (ld_state == L_DONE);
      cpu_hold = (ld_state != L_DONE);
   end

   // Word assembly, memory write strobe and sticky framing flag
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         word_total     <= '0;
         word_cnt       <= '0;
         byte_cnt       <= '0;
         word_buf       <= '0;
         finish_pending <= 1'b0;
         imem_we        <= 1'b0;
         imem_addr      <= '0;
         imem_wdata     <= '0;
         frame_err      <= 1'b0;
      end else begin
         imem_we        <= 1'b0;
         finish_pending <= 1'b0;
         if (byte_bad && ld_state != L_DONE) frame_err <= 1'b1;
         if (byte_ok) begin
            case (ld_state)
               L_COUNT: begin
                  word_total <= shift_reg;
                  word_cnt   <= '0;
                  byte_cnt   <= '0;
               end
               L_LOAD: begin
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     if ({24'd0, word_cnt} < DEPTH_U) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= {22'd0, word_cnt, 2'b00};
                        imem_wdata <= {word_buf, shift_reg};
                     end
                     word_cnt <= word_cnt + 8'd1;
                     if (word_cnt + 8'd1 == word_total) finish_pending <= 1'b1;
                  end else begin
                     word_buf <= {word_buf[15:0], shift_reg};
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per UART bit (even, >= 4).
REQ-002 Parameter DEPTH_WORDS, default 64: instruction-memory capacity in 32-bit words.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx  input  1  UART serial input: idle high, 8N1, LSB first; asynchronous to clock.
REQ-006 imem_we  output  1  one-cycle write strobe to the instruction ROM/RAM.
REQ-007 imem_addr  output  32  byte address of the word being written; always word-aligned.
REQ-008 imem_wdata  output  32  word being written.
REQ-009 cpu_hold  output  1  high while the CPU must stay in reset.
REQ-010 done  output  1  high once loading has completed.
REQ-011 frame_err  output  1  sticky flag: at least one byte had a bad stop bit.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer before use; all bit timing is relative to the synchronized signal.
REQ-013 Receiver FSM states: R_IDLE, R_START, R_DATA, R_STOP.
- R_IDLE -> R_START on a synchronized high-to-low transition.
REQ-014 R_START:
- Sample at CLKS_PER_BIT/2 cycles.
- Sample low -> R_DATA.
- Sample high -> false start; return to R_IDLE with no byte emitted.
REQ-015 R_DATA: sample 8 bits at CLKS_PER_BIT intervals from the start-bit midpoint, LSB first; then -> R_STOP.
REQ-016 R_STOP: sample the stop bit CLKS_PER_BIT cycles after the last data bit, then -> R_IDLE.
- Stop high: byte accepted.
- Stop low: byte discarded and frame_err set.
REQ-017 Loader FSM states: L_COUNT, L_LOAD, L_DONE.
REQ-018 L_COUNT: the first accepted byte is the word count N (0..255).
- N = 0 -> L_DONE.
- Otherwise -> L_LOAD, with the word counter and byte counter cleared.
REQ-019 L_LOAD: accepted bytes are assembled big-endian; the first byte of each group of four forms bits 31:24.
REQ-020 On the 4th byte of a group:
- imem_we SHALL pulse high for exactly one cycle, in the cycle after the stop-bit sample edge.
- imem_wdata = assembled word.
- imem_addr = word_index*4.
REQ-021 Overflow: words with word_index >= DEPTH_WORDS SHALL be consumed and counted, but imem_we SHALL stay low for them.
REQ-022 After word N is consumed, the loader SHALL move to L_DONE.
- done rises and cpu_hold falls in the cycle after that word's imem_we slot.
- For N = 0, this happens in the cycle after the count byte's stop-bit sample.
REQ-023 L_DONE is terminal until reset.
- rx activity is ignored: no writes, and frame_err does not change.
REQ-024 imem_addr and imem_wdata SHALL hold their last values when imem_we is low.
REQ-025 A discarded (bad-stop) byte SHALL NOT advance the byte counter; a partial word resumes with the next accepted byte.
REQ-026 imem_we and the done transition SHALL never coincide; at most one write occurs per received word.

Reset
REQ-027 Asserting reset (low) SHALL immediately force all of the following, independent of clock:
- receiver to R_IDLE;
- loader to L_COUNT;
- all counters to 0;
- imem_we=0, imem_addr=0, imem_wdata=0;
- cpu_hold=1, done=0, frame_err=0.
REQ-028 Reset asserted mid-byte or mid-word SHALL discard the partial data; no write SHALL occur for it.
REQ-029 After reset deassertion, the first falling edge on rx SHALL start a new count byte.

Verification
REQ-030 Single word: N=0x01, then bytes 0x20,0x08,0x00,0x05.
- One imem_we pulse with addr 0x00000000, data 0x20080005.
- Then done=1 and cpu_hold=0.
REQ-031 Three words: N=0x03, then 12 bytes.
- Writes at addrs 0x0, 0x4, 0x8 with the correct big-endian data.
- Exactly 3 pulses; done=1 one cycle after the third pulse.
REQ-032 N=0x00 -> no imem_we; done=1 and cpu_hold=0 in the cycle after the stop-bit sample.
REQ-033 Framing and glitch errors:
- Byte with a low stop bit inside a word -> frame_err=1, byte not counted; the following 4 good bytes still produce one correct word.
- A rx low glitch shorter than CLKS_PER_BIT/2 -> no byte emitted.
REQ-034 DEPTH_WORDS=2, N=3 -> writes at 0x0 and 0x4 only; the third word is consumed without a write, then done=1.
REQ-035 reset driven low after 2 bytes of word 1:
- outputs return to their reset values immediately and no write occurs;
- a full retransmission afterwards loads correctly from addr 0.
